// File: rtl/index_peak_pkg.sv
// rtl/index_peak_pkg.sv - shared widths, FSM state and sample type for the index peak tracker
package index_peak_pkg;

    localparam int INDEX_W = 8;
    localparam int CNT_W   = 16;
    localparam int FREQ_W  = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        TRACK   = 2'd3
    } state_t;

    // NONE samples carry a zero value so that whole-struct equality compares classes correctly
    typedef struct packed {
        logic               none;
        logic [INDEX_W-1:0] value;
    } sample_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/index_peak_freq_conv.sv
// rtl/index_peak_freq_conv.sv - registered bin index to frequency conversion (index * BIN_HZ)
module index_peak_freq_conv
    import index_peak_pkg::*;
#(
    parameter logic [CNT_W-1:0] BIN_HZ = 16'd390
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic [INDEX_W-1:0] index,
    output logic [FREQ_W-1:0]  freq
);

    // 8x16 unsigned product always fits 24 bits
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            freq <= '0;
        end else begin
            freq <= FREQ_W'(index) * FREQ_W'(BIN_HZ);
        end
    end

endmodule

// File: rtl/index_peak_tracker.sv
// rtl/index_peak_tracker.sv - qualifies a stable FFT peak bin; INDEX_PEAK_FREQ_EN enables freq_hz
module index_peak_tracker
    import index_peak_pkg::*;
#(
    parameter int unsigned      STABLE_CNT = 64,
    parameter int unsigned      MIN_INDEX  = 1,
    parameter logic [CNT_W-1:0] BIN_HZ     = 16'd390
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic [INDEX_W-1:0] max_index,
    output logic               locked,
    output logic [INDEX_W-1:0] locked_index,
    output logic               index_changed,
    output logic [FREQ_W-1:0]  freq_hz
);

    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CNT);

    state_t             state_q, state_d;
    sample_t            cand_q, cand_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               locked_q, locked_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic               chg_q, chg_d;

    sample_t            smp;
    logic               same_cand;
    logic               match_lock;
    logic [CNT_W-1:0]   next_cnt;
    logic               reached;

    always_comb begin
        smp.none  = ({24'd0, max_index} < MIN_INDEX);
        smp.value = smp.none ? '0 : max_index;
    end

    assign same_cand  = (smp == cand_q);
    assign match_lock = !smp.none && (smp.value == idx_q);
    assign next_cnt   = sat_inc(count_q);
    assign reached    = (next_cnt >= STABLE);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            count_q  <= '0;
            locked_q <= 1'b0;
            idx_q    <= '0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            count_q  <= count_d;
            locked_q <= locked_d;
            idx_q    <= idx_d;
            chg_q    <= chg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        count_d  = count_q;
        locked_d = locked_q;
        idx_d    = idx_q;
        chg_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!smp.none) begin
                    state_d = ACQUIRE;
                    cand_d  = smp;
                    count_d = 16'd1;
                end
            end
            ACQUIRE: begin
                if (smp.none) begin
                    state_d = IDLE;
                    cand_d  = '0;
                    count_d = '0;
                end else if (same_cand) begin
                    count_d = next_cnt;
                    if (reached) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        idx_d    = cand_q.value;
                        chg_d    = 1'b1;
                        count_d  = '0;
                    end
                end else begin
                    cand_d  = smp;
                    count_d = 16'd1;
                end
            end
            LOCKED: begin
                if (!match_lock) begin
                    state_d = TRACK;
                    cand_d  = smp;
                    count_d = 16'd1;
                end
            end
            TRACK: begin
                // NONE is a legitimate candidate here: a sustained NONE run drops the lock
                if (match_lock) begin
                    state_d = LOCKED;
                    count_d = '0;
                end else if (same_cand) begin
                    count_d = next_cnt;
                    if (reached) begin
                        chg_d   = 1'b1;
                        count_d = '0;
                        if (cand_q.none) begin
                            state_d  = IDLE;
                            locked_d = 1'b0;
                            idx_d    = '0;
                            cand_d   = '0;
                        end else begin
                            state_d = LOCKED;
                            idx_d   = cand_q.value;
                        end
                    end
                end else begin
                    cand_d  = smp;
                    count_d = 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign locked        = locked_q;
    assign locked_index  = idx_q;
    assign index_changed = chg_q;

`ifdef INDEX_PEAK_FREQ_EN
    index_peak_freq_conv #(
        .BIN_HZ (BIN_HZ)
    ) u_freq_conv (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .index   (idx_q),
        .freq    (freq_hz)
    );
`else
    logic unused_bin_hz;
    assign unused_bin_hz = ^BIN_HZ;
    assign freq_hz       = '0;
`endif

endmodule
